sc_core_oz_rf_sb: RTL
=====================

// Module: sc_core_oz_rf_sb
// PURPOSE
//  Parametrised integer register file with a load-writeback scoreboard for the sc_core_oz core family.
//  It has RD_PORTS combinational read ports and two write ports:
//   - wr0: early write, ALU/JAL result.
//   - wr1: late write, load data returning from a multi-cycle memory.
//  A per-register pending bit tracks outstanding late writes. The decode stage uses it to stall on RAW hazards.
//  Sits between decode (read and issue) and writeback (wr0/wr1) in the next-generation core.
// PARAMETERS
//  DATA_W    32                  register width in bits
//  NUM_REGS  32                  architectural registers; index 0 is hardwired zero
//  RD_PORTS  2                   number of read ports
//  ADDR_W    $clog2(NUM_REGS)    register index width (derived; do not override)
// PORTS
//  clk          in   1                  core clock; all state updates on the rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  rd_addr      in   RD_PORTS*ADDR_W    read indices, port p = bits [p*ADDR_W +: ADDR_W]
//  rd_data      out  RD_PORTS*DATA_W    read data per port
//  rd_busy      out  RD_PORTS           1 = indexed register has a pending late write
//  wr0_en       in   1                  early write enable
//  wr0_addr     in   ADDR_W             early write index
//  wr0_data     in   DATA_W             early write data
//  wr1_en       in   1                  late (load) write enable; clears the pending bit
//  wr1_addr     in   ADDR_W             late write index
//  wr1_data     in   DATA_W             late write data
//  issue_en     in   1                  a load is issued; sets pending[issue_addr]
//  issue_addr   in   ADDR_W             destination of the issued load
//  pending_cnt  out  ADDR_W+1           number of registers currently pending
//  sb_conflict  out  1                  1-cycle pulse on a scoreboard rule violation (see below)
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - all registers = 0, all pending = 0, pending_cnt = 0, sb_conflict = 0.
//    - Any in-flight load is forgotten; a wr1 arriving after reset is still written but clears nothing.
//  - Register 0:
//    - always reads 0 and is never busy.
//    - Writes and issues to index 0 are ignored, produce no conflict, and do not change pending_cnt.
//  - Reads are combinational from the register array; latency 0.
//  - Writes take effect at the rising edge; registered value is visible the following cycle
//    (same cycle only with the bypass option).
//  - wr0_addr == wr1_addr, both enabled, nonzero: wr0 wins.
//    - The ALU result is younger in program order.
//    - The pending bit is still cleared by wr1.
//  - Scoreboard next state per index i:
//    - set if issue_en & issue_addr==i;
//    - else clear if wr1_en & wr1_addr==i;
//    - else hold.
//    - Issue and wr1 to the same index in one cycle leaves it pending (the new load owns it).
//  - pending_cnt is a registered counter = popcount(pending), updated incrementally by -1, 0 or +1 per cycle.
//    - Issue and clear of different indices in one cycle gives net 0.
//    - The counter never wraps; its range is 0..NUM_REGS-1.
//  - sb_conflict is registered and pulses for one cycle after any of:
//    - issue_en to an already-pending index whose pending bit is not cleared by wr1 in the same cycle (WAW on load);
//    - wr0_en to a pending index (ALU write racing an outstanding load);
//    - wr1_en to a non-pending index (orphan load return).
//    - The write still happens in all cases; pending state follows the rules above.
//  - rd_busy[p] = pending[rd_addr[p]] (as modified by the bypass option).
//  - rd_addr values >= NUM_REGS read 0, are not busy, and are ignored as write or issue targets.
// CONFIGURATION
//  SC_CORE_OZ_RF_BYPASS_EN defined:
//   - rd_data[p] is forwarded from the same-cycle write matching rd_addr[p] (priority wr0 over wr1, then array).
//   - rd_busy[p] is forced to 0 when wr1_en & wr1_addr==rd_addr[p] and no issue targets that index this cycle.
//  SC_CORE_OZ_RF_BYPASS_EN undefined:
//   - no forwarding; rd_data and rd_busy reflect only registered state.
//   - Decode stalls one extra cycle after a load return.
// TESTING
//  1 Reset: drive rst_n low mid-cycle with pending bits set -> immediately all rd_data=0, rd_busy=0, pending_cnt=0.
//  2 wr0 x5=0x1234_5678, read x5 next cycle -> 0x1234_5678. Write x0=0xFFFF_FFFF -> x0 reads 0.
//  3 issue x7; check rd_busy=1 and pending_cnt=1; wr1 x7=0xCAFE_0001 three cycles later.
//    - Bypass on: same cycle rd_data=0xCAFE_0001, rd_busy=0.
//    - Bypass off: values appear next cycle.
//  4 Same cycle: wr0 x3=0xA, wr1 x3=0xB, x3 pending -> next cycle x3=0xA, pending[3]=0, pending_cnt decrements by 1.
//  5 Same cycle: issue x9, wr1 x9, x9 pending -> x9 stays busy, pending_cnt unchanged, sb_conflict stays 0.
//  6 Conflicts:
//    - issue x4 twice with no wr1 between -> sb_conflict=1 for exactly one cycle after the second issue;
//    - wr1 to x12 never issued -> sb_conflict pulse and x12 updated.

Source files
------------

// File: rtl/sc_core_oz_rf_sb_if.sv
// rtl/sc_core_oz_rf_sb_if.sv - bus bundle between decode/writeback and the sc_core_oz register file
//
// Purpose: groups the read, write, issue and scoreboard status signals of
//   sc_core_oz_rf_sb into one interface.
// Signals:
//   rd_addr/rd_data/rd_busy   RD_PORTS packed read ports, port p at [p*W +: W]
//   wr0_en/wr0_addr/wr0_data  early (ALU/JAL) write
//   wr1_en/wr1_addr/wr1_data  late (load return) write
//   issue_en/issue_addr       load issue, marks destination pending
//   pending_cnt               number of pending registers
//   sb_conflict               one-cycle scoreboard violation pulse
// Modports: master = decode/writeback side, slave = register file.
interface sc_core_oz_rf_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int RD_PORTS = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       wr0_en;
  logic [ADDR_W-1:0]          wr0_addr;
  logic [DATA_W-1:0]          wr0_data;
  logic                       wr1_en;
  logic [ADDR_W-1:0]          wr1_addr;
  logic [DATA_W-1:0]          wr1_data;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;
  logic [ADDR_W:0]            pending_cnt;
  logic                       sb_conflict;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    input  rd_data, rd_busy, pending_cnt, sb_conflict
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    output rd_data, rd_busy, pending_cnt, sb_conflict
  );
endinterface

// File: rtl/sc_core_oz_rf_sb.sv
// rtl/sc_core_oz_rf_sb.sv - integer register file with load-writeback scoreboard
//
// Purpose: RD_PORTS combinational read ports, an early write port (wr0, ALU/JAL)
//   and a late write port (wr1, load return). A pending bit per register tracks
//   outstanding loads so decode can stall on RAW hazards. x0 is hardwired zero.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   rf     sc_core_oz_rf_sb_if.slave (read ports, wr0, wr1, issue, pending_cnt,
//          sb_conflict)
// Configuration macro: SC_CORE_OZ_RF_BYPASS_EN
//   defined   - reads forward same-cycle wr0/wr1 data and drop busy on a
//               same-cycle load return
//   undefined - reads reflect registered state only
module sc_core_oz_rf_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int RD_PORTS = 2
) (
  input logic               clk,
  input logic               rst_n,
  sc_core_oz_rf_sb_if.slave rf
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  // Indices that are real, writable registers: nonzero and below NUM_REGS.
  // Built as a table so every index value is covered without range compares.
  logic [DEPTH-1:0] idx_ok;
  for (genvar i = 0; i < DEPTH; i++) begin : g_idx_ok
    assign idx_ok[i] = (i != 0) && (i < NUM_REGS);
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [CNT_W-1:0]  cnt;
  logic              conflict;

  logic wr0_v, wr1_v, iss_v;
  logic iss_hits_wr1;
  logic clr_v;
  logic inc, dec;
  logic waw, alu_race, orphan;

  assign wr0_v = rf.wr0_en   & idx_ok[rf.wr0_addr];
  assign wr1_v = rf.wr1_en   & idx_ok[rf.wr1_addr];
  assign iss_v = rf.issue_en & idx_ok[rf.issue_addr];

  // A new load to the same index as a returning load takes ownership: the
  // pending bit stays set and the returning load does not clear it.
  assign iss_hits_wr1 = iss_v & wr1_v & (rf.issue_addr == rf.wr1_addr);
  assign clr_v        = wr1_v & ~iss_hits_wr1;

  // Counter moves only on real 0->1 / 1->0 transitions of a pending bit.
  assign inc = iss_v & ~pending[rf.issue_addr];
  assign dec = clr_v &  pending[rf.wr1_addr];

  assign waw      = iss_v & pending[rf.issue_addr] & ~iss_hits_wr1;
  assign alu_race = wr0_v & pending[rf.wr0_addr];
  assign orphan   = wr1_v & ~pending[rf.wr1_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending  <= '0;
      cnt      <= '0;
      conflict <= 1'b0;
    end else begin
      // wr0 is younger in program order, so its later assignment wins.
      if (wr1_v) regs[rf.wr1_addr] <= rf.wr1_data;
      if (wr0_v) regs[rf.wr0_addr] <= rf.wr0_data;

      if (clr_v) pending[rf.wr1_addr]   <= 1'b0;
      if (iss_v) pending[rf.issue_addr] <= 1'b1;

      if (inc & ~dec) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec & ~inc) begin
        cnt <= cnt - CNT_W'(1);
      end

      conflict <= waw | alu_race | orphan;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ok;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = rf.rd_addr[p*ADDR_W +: ADDR_W];
    assign ok = idx_ok[ra];

`ifdef SC_CORE_OZ_RF_BYPASS_EN
    always_comb begin
      d = regs[ra];
      b = pending[ra];
      if (wr0_v && (rf.wr0_addr == ra)) begin
        d = rf.wr0_data;
      end else if (wr1_v && (rf.wr1_addr == ra)) begin
        d = rf.wr1_data;
      end
      // clr_v already excludes a same-cycle issue to the returning index.
      if (clr_v && (rf.wr1_addr == ra)) begin
        b = 1'b0;
      end
    end
`else
    assign d = regs[ra];
    assign b = pending[ra];
`endif

    assign rf.rd_data[p*DATA_W +: DATA_W] = ok ? d : '0;
    assign rf.rd_busy[p]                  = ok & b;
  end

  assign rf.pending_cnt = cnt;
  assign rf.sb_conflict = conflict;
endmodule
